// File: rtl/window_scan_controller.sv
// Raster-scan sequencer for the KxK sliding-window stage.
// Accepts one IMG_W x IMG_H frame over a valid/ready stream, strobes the
// line-buffer shift on every accepted pixel and presents the top-left
// coordinates of each complete window, honouring downstream backpressure.
module window_scan_controller #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int K     = 3,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          pix_valid_i,
  output logic          pix_ready_o,
  input  logic          out_ready_i,
  output logic          shift_en_o,
  output logic          win_valid_o,
  output logic [RW-1:0] win_row_o,
  output logic [CW-1:0] win_col_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [CW-1:0] EDGE_COL = CW'(K - 1);
  localparam logic [RW-1:0] EDGE_ROW = RW'(K - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;

  logic accept;
  logic at_last_col;
  logic at_last_row;
  logic window_pos;

  // A pixel may enter only while running and while any pending window is
  // either absent or being consumed this cycle.
  assign pix_ready_o  = (state_q == S_RUN) & (~win_valid_q | out_ready_i);
  assign accept       = pix_valid_i & pix_ready_o;
  assign shift_en_o   = accept;
  assign at_last_col  = (col_q == LAST_COL);
  assign at_last_row  = (row_q == LAST_ROW);
  // The accepted pixel is the bottom-right corner of a full window.
  assign window_pos   = (row_q >= EDGE_ROW) & (col_q >= EDGE_COL);

  assign win_valid_o  = win_valid_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign busy_o       = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign frame_done_o = (state_q == S_DONE);

  // Frame FSM and raster position counters.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (at_last_col) begin
            col_d = '0;
            if (at_last_row) begin
              row_d   = '0;
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave once the final window has been taken (or was never pending).
        if (!win_valid_q || out_ready_i) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window presentation: a new window overrides a consume in the same cycle,
  // so a simultaneous consume-and-produce keeps valid high with new coordinates.
  always_comb begin
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (accept && window_pos) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q - EDGE_ROW;
      win_col_d   = col_q - EDGE_COL;
    end else if (out_ready_i) begin
      win_valid_d = 1'b0;
    end
  end

  // State register with synchronous reset; a reset mid-frame discards it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

endmodule

// File: tb/tb_window_scan_controller.sv
// Directed bench for window_scan_controller: an 8x6 K=3 instance for the
// main scenarios and a 3x3 K=3 instance for the minimum frame.
module tb_window_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pv, ordy;
  logic       pr, se, wv, busy, fd;
  logic [2:0] wr, wc;

  logic       m_start, m_pv, m_ordy;
  logic       m_pr, m_se, m_wv, m_busy, m_fd;
  logic [1:0] m_wr, m_wc;

  int checks   = 0;
  int failures = 0;

  // Per-frame statistics gathered by cyc().
  int cyc_no, n_shift, n_win, n_done, order_err, exp_idx;
  int acc18_cyc, last_acc_cyc, first_cyc, done_cyc;
  int first_r, first_c, last_r, last_c;
  bit seen_first;
  logic s_pr, s_se;

  always #5 clk = ~clk;

  window_scan_controller #(.IMG_W(8), .IMG_H(6), .K(3)) dut (
    .clk(clk), .rst(rst), .start_i(start), .pix_valid_i(pv),
    .pix_ready_o(pr), .out_ready_i(ordy), .shift_en_o(se),
    .win_valid_o(wv), .win_row_o(wr), .win_col_o(wc),
    .busy_o(busy), .frame_done_o(fd)
  );

  window_scan_controller #(.IMG_W(3), .IMG_H(3), .K(3)) dut_min (
    .clk(clk), .rst(rst), .start_i(m_start), .pix_valid_i(m_pv),
    .pix_ready_o(m_pr), .out_ready_i(m_ordy), .shift_en_o(m_se),
    .win_valid_o(m_wv), .win_row_o(m_wr), .win_col_o(m_wc),
    .busy_o(m_busy), .frame_done_o(m_fd)
  );

  task automatic clear_stats();
    cyc_no = 0; n_shift = 0; n_win = 0; n_done = 0; order_err = 0;
    exp_idx = 0; acc18_cyc = -1; last_acc_cyc = -1; first_cyc = -1;
    done_cyc = -1; first_r = -1; first_c = -1; last_r = -1; last_c = -1;
    seen_first = 0;
  endtask

  // Called at a negedge: drive inputs, sample, score, advance to next negedge.
  // Windows are expected in raster order over a 6-wide, 4-high grid.
  task automatic cyc(input logic st, input logic v, input logic r);
    start = st; pv = v; ordy = r;
    #1;
    s_pr = pr; s_se = se;
    if (se) begin
      if (n_shift == 18) acc18_cyc = cyc_no;
      n_shift++;
      last_acc_cyc = cyc_no;
    end
    if (wv) begin
      if (!seen_first) begin
        seen_first = 1; first_cyc = cyc_no; first_r = wr; first_c = wc;
      end
      if (r) begin
        if (wr !== 3'(exp_idx / 6) || wc !== 3'(exp_idx % 6) || exp_idx > 23)
          order_err++;
        last_r = wr; last_c = wc; exp_idx++; n_win++;
      end
    end
    if (fd) begin n_done++; done_cyc = cyc_no; end
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input bit timed_out);
    checks++;
    if (timed_out) begin
      failures++; $display("FAIL %s_timeout: frame_done never seen", tag);
    end
    checks++;
    if (n_win !== 24) begin
      failures++; $display("FAIL %s_win_count: got %0d want 24", tag, n_win);
    end
    checks++;
    if (order_err !== 0) begin
      failures++; $display("FAIL %s_order: %0d out-of-order windows", tag, order_err);
    end
    checks++;
    if (n_shift !== 48) begin
      failures++; $display("FAIL %s_shift_count: got %0d want 48", tag, n_shift);
    end
    checks++;
    if (n_done !== 1) begin
      failures++; $display("FAIL %s_done_count: got %0d want 1", tag, n_done);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; pv = 0; ordy = 0;
    m_start = 0; m_pv = 0; m_ordy = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    pv = 1; ordy = 1;
    #1;
    checks++;
    if ({pr, se, wv, busy, fd} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 00000", {pr, se, wv, busy, fd});
    end
    checks++;
    if (wr !== 3'd0 || wc !== 3'd0) begin
      failures++; $display("FAIL reset_coords: got (%0d,%0d) want (0,0)", wr, wc);
    end
    @(negedge clk);
    #1;
    checks++;
    if (se !== 1'b0) begin
      failures++; $display("FAIL idle_valid_no_shift: shift_en %b want 0", se);
    end
    @(negedge clk);
  endtask

  task automatic test_continuous();
    bit to;
    clear_stats();
    cyc(1, 1, 1);
    while (n_done == 0 && cyc_no < 200) cyc(0, 1, 1);
    to = (n_done == 0);
    repeat (3) cyc(0, 0, 1);
    check_frame("cont", to);
    checks++;
    if (first_r !== 0 || first_c !== 0) begin
      failures++; $display("FAIL cont_first_coord: got (%0d,%0d) want (0,0)", first_r, first_c);
    end
    checks++;
    if (first_cyc !== acc18_cyc + 1 || acc18_cyc !== 19) begin
      failures++; $display("FAIL cont_first_latency: window cyc %0d accept(2,2) cyc %0d want 20/19",
                           first_cyc, acc18_cyc);
    end
    checks++;
    if (last_r !== 3 || last_c !== 5) begin
      failures++; $display("FAIL cont_last_coord: got (%0d,%0d) want (3,5)", last_r, last_c);
    end
    checks++;
    if (done_cyc !== last_acc_cyc + 2) begin
      failures++; $display("FAIL cont_done_latency: done cyc %0d last accept cyc %0d want +2",
                           done_cyc, last_acc_cyc);
    end
  endtask

  task automatic test_backpressure();
    int stall_left = 5;
    int viol = 0;
    logic r;
    bit to;
    clear_stats();
    cyc(1, 1, 1);
    while (n_done == 0 && cyc_no < 300) begin
      r = 1;
      if (wv && wr == 3'd1 && wc == 3'd2 && stall_left > 0) r = 0;
      cyc(0, 1, r);
      if (!r) begin
        stall_left--;
        if (s_pr !== 1'b0 || s_se !== 1'b0) viol++;
      end
    end
    to = (n_done == 0);
    check_frame("bp", to);
    checks++;
    if (stall_left !== 0) begin
      failures++; $display("FAIL bp_stable: %0d stall cycles not held on (1,2)", stall_left);
    end
    checks++;
    if (viol !== 0) begin
      failures++; $display("FAIL bp_ready_low: %0d stall cycles with ready/shift high", viol);
    end
  endtask

  task automatic test_random();
    bit to;
    clear_stats();
    cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while (n_done == 0 && cyc_no < 2000)
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    to = (n_done == 0);
    check_frame("rand", to);
  endtask

  task automatic test_reset_midframe();
    bit to;
    clear_stats();
    cyc(1, 1, 1);
    while (n_shift < 20 && cyc_no < 100) cyc(0, 1, 1);
    rst = 1; pv = 1; ordy = 1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({pr, se, wv, busy, fd} !== 5'b0 || wr !== 3'd0 || wc !== 3'd0) begin
      failures++;
      $display("FAIL midreset_idle: flags %b coords (%0d,%0d) want 00000 (0,0)",
               {pr, se, wv, busy, fd}, wr, wc);
    end
    @(negedge clk);
    clear_stats();
    cyc(1, 1, 1);
    while (n_done == 0 && cyc_no < 200) cyc(0, 1, 1);
    to = (n_done == 0);
    check_frame("midreset", to);
  endtask

  task automatic test_start_ignored();
    int viol = 0;
    logic st;
    bit to;
    clear_stats();
    cyc(1, 1, 1);
    while (n_done == 0 && cyc_no < 200) begin
      st = (n_shift == 10) || (busy && n_shift == 48);
      cyc(st, 1, 1);
    end
    to = (n_done == 0);
    check_frame("startign", to);
    repeat (4) begin
      cyc(0, 1, 1);
      if (busy !== 1'b0 || s_se !== 1'b0) viol++;
    end
    checks++;
    if (viol !== 0) begin
      failures++; $display("FAIL startign_idle: %0d idle cycles with busy/shift", viol);
    end
  endtask

  task automatic test_min_frame();
    int acc = 0, wins = 0, dones = 0, n = 0;
    int last_acc = -1, win_cyc = -1, d_cyc = -1;
    int wrow = -1, wcol = -1;
    m_start = 1; m_pv = 1; m_ordy = 1;
    while (dones == 0 && n < 50) begin
      #1;
      if (m_se) begin acc++; last_acc = n; end
      if (m_wv) begin wins++; win_cyc = n; wrow = m_wr; wcol = m_wc; end
      if (m_fd) begin dones++; d_cyc = n; end
      @(negedge clk);
      m_start = 0;
      n++;
    end
    checks++;
    if (acc !== 9 || wins !== 1) begin
      failures++; $display("FAIL min_counts: accepts %0d windows %0d want 9/1", acc, wins);
    end
    checks++;
    if (wrow !== 0 || wcol !== 0 || win_cyc !== last_acc + 1) begin
      failures++; $display("FAIL min_window: (%0d,%0d) at %0d want (0,0) at %0d",
                           wrow, wcol, win_cyc, last_acc + 1);
    end
    checks++;
    if (dones !== 1 || d_cyc !== last_acc + 2) begin
      failures++; $display("FAIL min_done: pulses %0d at %0d want 1 at %0d",
                           dones, d_cyc, last_acc + 2);
    end
    m_pv = 0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_random();
    test_reset_midframe();
    test_start_ignored();
    test_min_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
